// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: memory command encodings, sequencer states and the halt opcode.
package fetch_sequencer_pkg;
  typedef enum logic [1:0] {MNONE = 2'b00, MREAD = 2'b01, MWRITE = 2'b10} mem_cmd_t;
  typedef enum logic [2:0] {S_RST, S_IF1, S_IF2, S_UPD, S_DISP, S_EXEC, S_DRD, S_HALT} state_t;
  localparam logic [2:0] HALT_OP = 3'b111;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: load/store request channel between the execute FSM and the sequencer.
//   master (execute FSM): drives data_req, data_we, data_addr; receives data_ack, data_rdata
//   slave  (sequencer):   receives the request, drives data_ack and data_rdata
interface fetch_sequencer_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic              data_ack;
  logic [DATA_W-1:0] data_rdata;
  modport master (output data_req, data_we, data_addr, input data_ack, data_rdata);
  modport slave (input data_req, data_we, data_addr, output data_ack, data_rdata);
endinterface

// File: rtl/fetch_sequencer_pc_reg.sv
// fetch_sequencer_pc_reg: program counter; priority reset > load > increment, wraps mod 2^ADDR_W.
//   clk, reset: clock and synchronous active-high reset (loads RESET_PC)
//   inc: advance by one; load/load_val: branch target load; pc: current value
module fetch_sequencer_pc_reg #(
  parameter int ADDR_W = 9,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);
  always_ff @(posedge clk)
    pc <= reset ? ADDR_W'(RESET_PC) : load ? load_val : inc ? pc + ADDR_W'(1) : pc;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns PC and IR, fetches instructions and arbitrates the shared I/D memory.
//   clk, reset: clock and synchronous active-high reset
//   ir, pc: current instruction and program counter
//   exec_start/exec_done: one-cycle start pulse to and completion level from the execute FSM
//   halted: high while halted on opcode 3'b111
//   dbus: load/store request channel (slave side)
//   pc_load/pc_in: branch target load, honoured only when FETCH_BRANCH_EN is defined
//   mem_cmd/mem_addr/mem_rdata: single-port memory with 1-cycle synchronous read
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] pc,
  output logic              exec_start,
  input  logic              exec_done,
  output logic              halted,
  fetch_sequencer_if.slave  dbus,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t state;
  logic is_halt, ld, st, pc_ld;
  assign is_halt = ir[DATA_W-1 -: 3] == HALT_OP;
  assign ld = state == S_EXEC && dbus.data_req && !dbus.data_we;
  assign st = state == S_EXEC && dbus.data_req && dbus.data_we;
`ifdef FETCH_BRANCH_EN
  assign pc_ld = state == S_EXEC && pc_load;
`else
  logic unused_pc_load;
  assign unused_pc_load = pc_load;
  assign pc_ld = 1'b0;
`endif
  fetch_sequencer_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) pc_reg (
    .clk(clk),
    .reset(reset),
    .inc(state == S_UPD),
    .load(pc_ld),
    .load_val(pc_in),
    .pc(pc)
  );
  // exec_start and halted are registered one state ahead so they are valid throughout DISP/HALT
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RST;
      ir <= '0;
      exec_start <= 1'b0;
      halted <= 1'b0;
    end else begin
      exec_start <= state == S_UPD && !is_halt;
      halted <= state == S_HALT || (state == S_DISP && is_halt);
      case (state)
        S_RST: state <= S_IF1;
        S_IF1: state <= S_IF2;
        S_IF2: begin
          ir <= mem_rdata;
          state <= S_UPD;
        end
        S_UPD: state <= S_DISP;
        S_DISP: state <= is_halt ? S_HALT : S_EXEC;
        S_EXEC: state <= exec_done ? S_IF1 : ld ? S_DRD : S_EXEC;
        S_DRD: state <= S_EXEC;
        default: state <= S_HALT;
      endcase
    end
  end
  // The memory command depends only on the request, never on exec_done; a request arriving
  // together with exec_done is simply not acknowledged and the FSM leaves for IF1.
  always_comb begin
    mem_cmd = (state == S_IF1 || state == S_IF2 || state == S_DRD || ld) ? MREAD : st ? MWRITE : MNONE;
    mem_addr = (state == S_DRD || ld || st) ? dbus.data_addr : state == S_RST ? '0 : pc;
    dbus.data_ack = state == S_DRD || (st && !exec_done);
    dbus.data_rdata = mem_rdata;
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized checks of fetch_sequencer against a program-level model.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;
  localparam int AW = 9;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0] ir;
  logic [AW-1:0] pc;
  logic exec_start, halted;
  logic exec_done = 1'b0;
  logic pc_load = 1'b0;
  logic [AW-1:0] pc_in = '0;
  logic [1:0] mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] mem [512];
  logic [DW-1:0] ref_mem [512];
  int checks = 0;
  int failures = 0;
  fetch_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) dbus ();
  fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0)) dut (
    .clk(clk),
    .reset(reset),
    .ir(ir),
    .pc(pc),
    .exec_start(exec_start),
    .exec_done(exec_done),
    .halted(halted),
    .dbus(dbus),
    .pc_load(pc_load),
    .pc_in(pc_in),
    .mem_cmd(mem_cmd),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_cmd == MWRITE) mem[mem_addr] <= wdata;
    mem_rdata <= mem[mem_addr];
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  // Called in the cycle before IF1; ends in the first EXEC cycle of the instruction at e.
  task automatic await_fetch(input logic [8:0] e);
    int n;
    logic [8:0] nx;
    nx = e + 9'd1;
    n = 0;
    while (exec_start !== 1'b1 && n < 10) begin
      step();
      exec_done = 1'b0;
      pc_load = 1'b0;
      n++;
      if (n <= 2) begin
        chk("fetch_cmd", mem_cmd, MREAD);
        chk("fetch_addr", mem_addr, e);
      end
      if (n == 3) chk("upd_cmd", mem_cmd, MNONE);
    end
    chk("start_latency", n, 4);
    chk("start", exec_start, 1);
    chk("ir", ir, ref_mem[e]);
    chk("pc", pc, nx);
    if (e == 9'h1FF) chk("pc_wrap", pc, 0);
    step();
    chk("start_pulse", exec_start, 0);
  endtask
  task automatic do_load(input logic [8:0] a);
    dbus.data_req = 1'b1;
    dbus.data_we = 1'b0;
    dbus.data_addr = a;
    #1;
    chk("ld_cmd", mem_cmd, MREAD);
    chk("ld_addr", mem_addr, a);
    chk("ld_ack_early", dbus.data_ack, 0);
    step();
    chk("ld_cmd2", mem_cmd, MREAD);
    chk("ld_addr2", mem_addr, a);
    chk("ld_ack", dbus.data_ack, 1);
    chk("ld_data", dbus.data_rdata, ref_mem[a]);
    dbus.data_req = 1'b0;
    step();
  endtask
  task automatic do_store(input logic [8:0] a, input logic [15:0] d);
    dbus.data_req = 1'b1;
    dbus.data_we = 1'b1;
    dbus.data_addr = a;
    wdata = d;
    #1;
    chk("st_cmd", mem_cmd, MWRITE);
    chk("st_addr", mem_addr, a);
    chk("st_ack", dbus.data_ack, 1);
    ref_mem[a] = d;
    step();
    dbus.data_req = 1'b0;
  endtask
  initial begin
    int ops, idle, cnt;
    logic [8:0] exp_pc, a, tgt;
    logic [15:0] d;
    dbus.data_req = 1'b0;
    dbus.data_we = 1'b0;
    dbus.data_addr = '0;
    for (int i = 0; i < 512; i++) begin
      d = 16'($urandom) & 16'hDFFF;
      mem[i] = d;
      ref_mem[i] = d;
    end
    mem[0] = 16'hD105;
    ref_mem[0] = 16'hD105;
    mem[1] = 16'hE000;
    ref_mem[1] = 16'hE000;
    mem[9'h020] = 16'h1234;
    ref_mem[9'h020] = 16'h1234;
    repeat (3) step();
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_start", exec_start, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cmd", mem_cmd, MNONE);
    chk("rst_addr", mem_addr, 0);
    chk("rst_ack", dbus.data_ack, 0);
    reset = 1'b0;
    await_fetch(9'h000);
    do_load(9'h020);
    do_store(9'h021, 16'h0ABC);
    chk("st_mem", mem[9'h021], 16'h0ABC);
    dbus.data_req = 1'b1;
    dbus.data_we = 1'b1;
    dbus.data_addr = 9'h021;
    wdata = 16'h0111;
    #1;
    ref_mem[9'h021] = 16'h0111;
    step();
    dbus.data_addr = 9'h022;
    wdata = 16'h0222;
    #1;
    chk("st_held_cmd", mem_cmd, MWRITE);
    chk("st_held_addr", mem_addr, 9'h022);
    chk("st_held_ack", dbus.data_ack, 1);
    ref_mem[9'h022] = 16'h0222;
    step();
    dbus.data_req = 1'b0;
    chk("st_held_mem", mem[9'h022], 16'h0222);
    exec_done = 1'b1;
    #1;
    chk("done_cmd", mem_cmd, MNONE);
    step();
    exec_done = 1'b0;
    chk("halt_fetch_addr", mem_addr, 1);
    chk("halt_fetch_cmd", mem_cmd, MREAD);
    repeat (3) step();
    chk("halt_ir", ir, 16'hE000);
    chk("halt_no_start", exec_start, 0);
    chk("halt_pc", pc, 2);
    step();
    chk("halted", halted, 1);
    cnt = 0;
    repeat (20) begin
      step();
      if (exec_start !== 1'b0 || mem_cmd !== MNONE) cnt++;
    end
    chk("halt_quiet", cnt, 0);
    chk("halt_hold", halted, 1);
    mem[1] = 16'h2001;
    ref_mem[1] = 16'h2001;
    reset = 1'b1;
    step();
    chk("rerst_pc", pc, 0);
    chk("rerst_halted", halted, 0);
    reset = 1'b0;
    await_fetch(9'h000);
    dbus.data_req = 1'b1;
    dbus.data_we = 1'b0;
    dbus.data_addr = 9'h020;
    #1;
    step();
    chk("drd_ack", dbus.data_ack, 1);
    reset = 1'b1;
    step();
    chk("drdrst_cmd", mem_cmd, MNONE);
    chk("drdrst_ack", dbus.data_ack, 0);
    chk("drdrst_pc", pc, 0);
    dbus.data_req = 1'b0;
    reset = 1'b0;
    await_fetch(9'h000);
    exp_pc = 9'h001;
    for (int k = 0; k < 520; k++) begin
      ops = $urandom_range(0, 3);
      for (int j = 0; j < ops; j++) begin
        idle = $urandom_range(0, 2);
        repeat (idle) step();
        a = 9'($urandom);
        if ($urandom_range(0, 1) == 1) do_load(a);
        else do_store(a, 16'($urandom) & 16'hDFFF);
      end
      exec_done = 1'b1;
      #1;
      chk("done_cmd", mem_cmd, MNONE);
      await_fetch(exp_pc);
      exp_pc = exp_pc + 9'd1;
    end
    pc_load = 1'b1;
    pc_in = 9'h0AA;
    #1;
    step();
    pc_in = 9'h050;
    exec_done = 1'b1;
    #1;
`ifdef FETCH_BRANCH_EN
    tgt = 9'h050;
`else
    tgt = exp_pc;
`endif
    await_fetch(tgt);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Top-level sequencer that owns the program counter and instruction register and arbitrates the single-port instruction/data memory for the CPU. It fetches an instruction, hands it to the execute FSM with a one-cycle start pulse, and serves that FSM's load/store requests until it reports completion. It then fetches the next instruction, or halts on opcode 3'b111.

## Interface
- ADDR_W, 9: memory address width; PC width.
- DATA_W, 16: instruction/data word width.
- RESET_PC, 0: PC value loaded on reset.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ir  out  DATA_W  current instruction, to decoder
- pc  out  ADDR_W  current PC, for observation
- exec_start  out  1  one-cycle pulse: ir valid, execute FSM begins
- exec_done  in  1  execute FSM finished current instruction (level, sampled in EXEC)
- halted  out  1  high while in HALT
- data_req  in  1  execute FSM memory request
- data_we  in  1  1 = store, 0 = load; valid with data_req
- data_addr  in  ADDR_W  load/store address
- data_ack  out  1  request served this cycle
- data_rdata  out  DATA_W  load data, valid when data_ack and !data_we
- pc_load / pc_in  in  1 / ADDR_W  branch target load (see Configuration)
- mem_cmd  out  2  MNONE/MREAD/MWRITE
- mem_addr  out  ADDR_W  memory address
- mem_rdata  in  DATA_W  memory read data, 1-cycle synchronous read

## Operation
- Reset: synchronous, active-high. From any state, including mid-access, enter RST at the next edge. Reset values: PC=RESET_PC, ir=0, exec_start=0, data_ack=0, halted=0, mem_cmd=MNONE, mem_addr=0. An in-flight access is abandoned.
- States and transitions:
  - RST -> IF1.
  - IF1: mem_cmd=MREAD, mem_addr=PC -> IF2.
  - IF2: mem_cmd=MREAD, mem_addr=PC; ir<=mem_rdata at the edge -> UPD.
  - UPD: PC<=PC+1 mod 2^ADDR_W (0x1FF wraps to 0x000) -> DISP.
  - DISP: if ir[15:13]==3'b111 -> HALT. Otherwise assert exec_start -> EXEC.
  - EXEC:
    - exec_done -> IF1; takes priority, and a data_req in the same cycle is ignored.
    - data_req & data_we: mem_cmd=MWRITE, mem_addr=data_addr, data_ack=1 same cycle; stay in EXEC.
    - data_req & !data_we: mem_cmd=MREAD, mem_addr=data_addr -> DRD.
  - DRD: mem_cmd=MREAD, mem_addr=data_addr, data_ack=1, data_rdata=mem_rdata -> EXEC.
  - HALT: all outputs idle; halted=1. Only reset exits.
- In all other states: mem_cmd=MNONE, mem_addr=PC.
- A requester keeping data_req high in the cycle after data_ack issues a new request.
- data_rdata is combinationally mem_rdata and is valid only with data_ack on a load.

## Timing
- Reset low at edge 0 (state RST): IF1 cycle 1, IF2 cycle 2, UPD cycle 3, DISP cycle 4. exec_start is high during cycle 4.
- Fetch overhead per instruction: 4 cycles, from exec_done to the next exec_start.
- Store: 1 cycle (ack same cycle). Load: 2 cycles (ack in the second).
- No combinational path from exec_done to mem_cmd. The data_req/data_we/data_addr -> mem_cmd/mem_addr/data_ack path is combinational in EXEC.

## Configuration
- FETCH_BRANCH_EN defined: in EXEC, pc_load=1 sets PC<=pc_in at that edge.
  - Valid in the same cycle as exec_done; the next fetch uses pc_in.
  - Multiple pc_load pulses in one EXEC: the last one wins.
- FETCH_BRANCH_EN undefined: pc_load and pc_in are present but ignored. PC changes only in RST and UPD.

## Structure
- Shared package: mem_cmd encodings (MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10), state enum, HALT opcode constant 3'b111.
- One natural sub-module, pc_reg: ADDR_W register with reset-load, increment and optional branch-load; priority reset > load > increment.

## Test plan
- Reset, memory[0]=16'hD105: exec_start pulses in cycle 4; ir=16'hD105; pc=1; mem_addr=0 with MREAD in cycles 1–2.
- Load request in EXEC, data_addr=0x020, memory[0x020]=16'h1234: MREAD to 0x020 for 2 cycles; data_ack with data_rdata=16'h1234 in the second.
- Store request in EXEC, data_addr=0x021: MWRITE to 0x021 with data_ack in the same cycle; state remains EXEC.
- memory[1]=16'hE000, exec_done after the first instruction: enters HALT, halted=1, no further exec_start for 20 cycles; reset restarts at PC=0.
- PC=0x1FF fetch: after UPD, pc=0x000. With FETCH_BRANCH_EN, pc_load with pc_in=0x050 alongside exec_done: next fetch reads address 0x050.
- Reset asserted in DRD: next cycle mem_cmd=MNONE, data_ack=0, pc=RESET_PC; fetch restarts normally.
